// File: rtl/light_level_driver_if.sv
// Host/controller-side bundle for the light level driver: target handshake,
// light feedback, button presses and status.
interface light_level_driver_if;
  logic [1:0] target;
  logic       target_valid;
  logic       target_ready;
  logic [1:0] light;
  logic       button_up;
  logic       button_down;
  logic       busy;
  logic       done;
  logic       err;

  modport master (
    output target, target_valid, light,
    input  target_ready, button_up, button_down, busy, done, err
  );

  modport slave (
    input  target, target_valid, light,
    output target_ready, button_up, button_down, busy, done, err
  );
endinterface

// File: rtl/light_level_driver.sv
// Steps a 4-level light controller toward a requested level with single button
// presses, confirming each step. Optional retargeting while busy: LLD_RETARGET_EN.
module light_level_driver #(
  parameter int unsigned PRESS_LEN = 1,
  parameter int unsigned GAP_LEN   = 2,
  parameter int unsigned TIMEOUT   = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  light_level_driver_if.slave bus
);

  typedef enum logic [2:0] {IDLE, EVAL, PRESS, WAIT, GAP, DONE} state_e;

  localparam logic [7:0] PRESS_LAST = 8'(PRESS_LEN - 1);
  localparam logic [7:0] GAP_LAST   = 8'(GAP_LEN - 1);
  localparam logic [7:0] TO_CNT     = 8'(TIMEOUT);

  state_e     state_q, state_d;
  logic [1:0] tgt_q, tgt_d;
  logic [1:0] start_q, start_d;
  logic       dir_q, dir_d;
  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;
  logic       up_q, up_d;
  logic       down_q, down_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       ready_q, ready_d;

  logic       accept;
  logic       retgt;
  logic [1:0] step_lvl;

  assign accept   = bus.target_valid & ready_q;
  assign step_lvl = dir_q ? start_q + 2'd1 : start_q - 2'd1;

`ifdef LLD_RETARGET_EN
  assign retgt = accept & (state_q != IDLE);
`else
  assign retgt = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    start_d = start_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    err_d   = err_q;

    if (accept) begin
      tgt_d = bus.target;
      err_d = 1'b0;
    end

    unique case (state_q)
      IDLE: if (accept) state_d = EVAL;
      EVAL: begin
        // A new target arriving during evaluation is re-evaluated next cycle.
        if (retgt) begin
          state_d = EVAL;
        end else if (bus.light == tgt_q) begin
          state_d = DONE;
        end else begin
          start_d = bus.light;
          dir_d   = (tgt_q > bus.light);
          cnt_d   = '0;
          state_d = PRESS;
        end
      end
      PRESS: begin
        if (cnt_q == PRESS_LAST) begin
          cnt_d   = '0;
          state_d = WAIT;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + 8'd1;
        if (bus.light == step_lvl) begin
          cnt_d   = '0;
          state_d = (GAP_LEN == 0) ? EVAL : GAP;
        end else if ((bus.light != start_q) || (cnt_q + 8'd1 == TO_CNT)) begin
          // Error wins over the clear from a same-cycle accept.
          err_d   = 1'b1;
          state_d = retgt ? EVAL : IDLE;
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = EVAL;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE:    state_d = retgt ? EVAL : IDLE;
      default: state_d = IDLE;
    endcase

    up_d   = (state_d == PRESS) &  dir_d;
    down_d = (state_d == PRESS) & ~dir_d;
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
`ifdef LLD_RETARGET_EN
    ready_d = (state_d != PRESS);
`else
    ready_d = (state_d == IDLE);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tgt_q   <= '0;
      start_q <= '0;
      dir_q   <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      up_q    <= 1'b0;
      down_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      start_q <= start_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      up_q    <= up_d;
      down_q  <= down_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  assign bus.button_up    = up_q;
  assign bus.button_down  = down_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.err          = err_q;
  assign bus.target_ready = ready_q;

endmodule

// File: tb/tb_light_level_driver.sv
// Directed bench for light_level_driver with a behavioural light controller
// model; compile with LLD_RETARGET_EN to exercise retargeting.
module tb_light_level_driver;

`ifdef LLD_RETARGET_EN
  localparam bit RE = 1'b1;
`else
  localparam bit RE = 1'b0;
`endif

  logic clk;
  logic rst_n;
  light_level_driver_if bus ();

  light_level_driver #(.PRESS_LEN(1), .GAP_LEN(2), .TIMEOUT(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Controller model: mode 0 steps normally, 1 ignores presses, 2 jumps to 3 on up.
  int         mode;
  logic       ld;
  logic [1:0] ld_val;
  always @(posedge clk) begin
    if (ld) bus.light <= ld_val;
    else if (mode == 0) begin
      if (bus.button_up && bus.light != 2'd3) bus.light <= bus.light + 2'd1;
      else if (bus.button_down && bus.light != 2'd0) bus.light <= bus.light - 2'd1;
    end else if (mode == 2) begin
      if (bus.button_up) bus.light <= 2'd3;
    end
  end

  logic clr;
  int   up_rise, up_cyc, down_cyc, both_cnt, done_cnt;
  logic up_prev;
  always @(posedge clk) begin
    if (clr) begin
      up_rise <= 0; up_cyc <= 0; down_cyc <= 0; both_cnt <= 0; done_cnt <= 0;
      up_prev <= 1'b0;
    end else begin
      if (bus.button_up) up_cyc <= up_cyc + 1;
      if (bus.button_up && !up_prev) up_rise <= up_rise + 1;
      if (bus.button_down) down_cyc <= down_cyc + 1;
      if (bus.button_up && bus.button_down) both_cnt <= both_cnt + 1;
      if (bus.done) done_cnt <= done_cnt + 1;
      up_prev <= bus.button_up;
    end
  end

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic send(input logic [1:0] t);
    bus.target = t;
    bus.target_valid = 1'b1;
    tick();
    bus.target_valid = 1'b0;
  endtask

  task automatic load_light(input logic [1:0] v);
    ld = 1'b1; ld_val = v;
    tick();
    ld = 1'b0;
  endtask

  task automatic clear_mon();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  // which: 0 = done, 1 = err, 2 = button_up
  task automatic wait_for(input int which, input int maxc, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < maxc && !seen; i++) begin
      if ((which == 0 && bus.done) || (which == 1 && bus.err) || (which == 2 && bus.button_up))
        seen = 1'b1;
      else
        tick();
    end
  endtask

  bit seen;
  int n;

  initial begin
    rst_n = 1'b0; mode = 0; ld = 1'b0; ld_val = '0; clr = 1'b1;
    bus.target = '0; bus.target_valid = 1'b0; bus.light = '0;
    tick(); tick();
    check("rst_up",    bus.button_up,    0);
    check("rst_down",  bus.button_down,  0);
    check("rst_busy",  bus.busy,         0);
    check("rst_done",  bus.done,         0);
    check("rst_err",   bus.err,          0);
    check("rst_ready", bus.target_ready, 1);
    rst_n = 1'b1;
    clr = 1'b0;

    // 0 -> 3: three single-cycle ups
    load_light(2'd0);
    clear_mon();
    send(2'd3);
    check("eval_ready", bus.target_ready, RE);
    check("eval_busy",  bus.busy, 1);
    wait_for(0, 100, seen);
    check("up3_done_seen", seen, 1);
    check("up3_busy_with_done", bus.busy, 1);
    tick();
    check("up3_done_width", bus.done, 0);
    check("up3_busy_fall", bus.busy, 0);
    tick();
    check("up3_rises",  up_rise, 3);
    check("up3_cycles", up_cyc, 3);
    check("up3_downs",  down_cyc, 0);
    check("up3_light",  bus.light, 3);
    check("up3_donecnt", done_cnt, 1);
    check("up3_err",    bus.err, 0);

    // 3 -> 1: two downs
    clear_mon();
    send(2'd1);
    wait_for(0, 100, seen);
    check("dn_done_seen", seen, 1);
    tick();
    check("dn_busy_fall", bus.busy, 0);
    tick();
    check("dn_cycles", down_cyc, 2);
    check("dn_ups",    up_cyc, 0);
    check("dn_light",  bus.light, 1);
    check("dn_donecnt", done_cnt, 1);

    // equal target: done in the second cycle after accept
    load_light(2'd2);
    clear_mon();
    send(2'd2);
    check("eq_done_c1", bus.done, 0);
    check("eq_busy_c1", bus.busy, 1);
    tick();
    check("eq_done_c2", bus.done, 1);
    tick();
    check("eq_done_c3", bus.done, 0);
    check("eq_busy_c3", bus.busy, 0);
    check("eq_buttons", up_cyc + down_cyc, 0);

    // no response: timeout after 8 WAIT cycles
    mode = 1;
    load_light(2'd0);
    clear_mon();
    send(2'd2);
    wait_for(2, 20, seen);
    check("to_up_seen", seen, 1);
    n = 0;
    tick();
    while (!bus.err && n < 50) begin
      n++;
      tick();
    end
    check("to_wait_cycles", n, 8);
    check("to_err",  bus.err, 1);
    check("to_busy", bus.busy, 0);
    tick();
    check("to_rises", up_rise, 1);
    check("to_nodone", done_cnt, 0);
    check("to_err_sticky", bus.err, 1);
    mode = 0;
    send(2'd0);
    check("to_err_cleared", bus.err, 0);
    wait_for(0, 20, seen);
    check("to_retry_done", seen, 1);
    tick();

    // wrong-direction step
    mode = 2;
    load_light(2'd0);
    clear_mon();
    send(2'd1);
    wait_for(1, 30, seen);
    check("wr_err_seen", seen, 1);
    check("wr_busy", bus.busy, 0);
    tick();
    check("wr_light", bus.light, 3);
    check("wr_nodone", done_cnt, 0);
    mode = 0;

    // async reset during PRESS
    load_light(2'd0);
    send(2'd3);
    wait_for(2, 20, seen);
    check("rp_up_seen", seen, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rp_up",    bus.button_up, 0);
    check("rp_down",  bus.button_down, 0);
    check("rp_busy",  bus.busy, 0);
    check("rp_done",  bus.done, 0);
    check("rp_err",   bus.err, 0);
    check("rp_ready", bus.target_ready, 1);
    tick();
    rst_n = 1'b1;
    tick();
    check("rp_light", bus.light, 0);

    // retarget during the first WAIT
    clear_mon();
    send(2'd3);
    wait_for(2, 20, seen);
    check("rt_up_seen", seen, 1);
    tick();
    check("rt_wait_ready", bus.target_ready, RE);
    send(2'd1);
    wait_for(0, 100, seen);
    check("rt_done_seen", seen, 1);
    tick(); tick();
    check("rt_light", bus.light, RE ? 1 : 3);
    check("rt_rises", up_rise, RE ? 1 : 3);
    check("rt_donecnt", done_cnt, 1);
    check("rt_both", both_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
